scurve_duty_gen: RTL and testbench

Jerk-limited (S-curve) duty-reference generator that sits directly upstream of the PWM stage and drives its 32-bit duty input. On a load request it latches a target duty and moves its output from the current value to the target. Acceleration ramps up, holds at a cap, and ramps down in integer jerk steps, with one update per prescaled tick. The PWM stage compares this output against its free-running ramp.

---
 rtl/scurve_duty_gen.sv | 139 +++++++++++++
 tb/tb_scurve_duty_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scurve_duty_gen.sv
// scurve_duty_gen
//   Jerk-limited (S-curve) duty-reference generator feeding the PWM duty input.
//   On an accepted load the target is clamped to DUTY_MAX and latched. The
//   output then walks toward it with one profile update per prescaler tick.
//   The acceleration level n ramps up, holds at NMAX, and ramps down so that
//   duty lands exactly on the target without overshoot.
//
// Ports:
//   Clk     in   1   system clock, posedge
//   Rst_n   in   1   asynchronous active-low reset
//   target  in  32   requested duty, sampled only on an accepted load
//   load    in   1   single-cycle request, honoured only when idle
//   duty    out 32   registered duty reference
//   busy    out  1   high while a profile is in progress
//   done    out  1   one-cycle pulse on the edge where duty reaches the target
module scurve_duty_gen #(
    parameter int unsigned TICK_DIV = 50000,
    parameter logic [31:0] JERK     = 32'd1000,
    parameter int unsigned NMAX     = 16,
    parameter logic [31:0] DUTY_MAX = 32'hFFFF_FFFF
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] target,
    input  logic        load,
    output logic [31:0] duty,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned N_W  = (NMAX > 0) ? $clog2(NMAX + 1) : 1;

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t          state;
    logic [PS_W-1:0] ps_cnt;
    logic            tick;
    logic [31:0]     tgt;
    logic            dir_up;
    logic [N_W-1:0]  n;

    logic [31:0]     clamped;
    logic [31:0]     rem;
    logic [63:0]     rem_w;
    logic [63:0]     n_w;
    logic [N_W-1:0]  n_next;
    logic [63:0]     step_w;
    logic            final_step;

    // Distance covered while braking from level k down to zero:
    // JERK * k*(k-1)/2, kept in 64 bits so large JERK values cannot wrap.
    function automatic logic [63:0] brake_dist(input logic [63:0] k);
        logic [63:0] tri_num;
        tri_num = (k * (k - 64'd1)) >> 1;
        return tri_num * {32'd0, JERK};
    endfunction

    // Free-running prescaler; load never restarts it.
    assign tick = (ps_cnt == PS_W'(TICK_DIV - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    assign clamped = (target > DUTY_MAX) ? DUTY_MAX : target;

    // Next acceleration level and step size for the current remaining distance.
    // Accelerate only if there is still room to brake from one level higher;
    // hold if braking from the current level still fits; otherwise back off.
    always_comb begin
        rem   = dir_up ? (tgt - duty) : (duty - tgt);
        rem_w = {32'd0, rem};
        n_w   = {{(64 - N_W){1'b0}}, n};
        if ((n_w < 64'(NMAX)) && (rem_w >= brake_dist(n_w + 64'd2))) begin
            n_next = n + N_W'(1);
        end else if ((n != '0) && (rem_w >= brake_dist(n_w + 64'd1))) begin
            n_next = n;
        end else if (n != '0) begin
            n_next = n - N_W'(1);
        end else begin
            n_next = '0;
        end
        step_w     = {{(64 - N_W){1'b0}}, n_next} * {32'd0, JERK};
        // A level of zero means the remaining gap is below one jerk step;
        // snap straight to the target in that case as well.
        final_step = (step_w >= rem_w) || (n_next == '0);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            duty   <= '0;
            tgt    <= '0;
            dir_up <= 1'b1;
            n      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        tgt    <= clamped;
                        dir_up <= (clamped >= duty);
                        busy   <= 1'b1;
                        state  <= RAMP;
                    end
                end
                RAMP: begin
                    if (tick) begin
                        if (final_step) begin
                            duty  <= tgt;
                            n     <= '0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            // step < rem here, so the low word holds the whole step
                            duty <= dir_up ? (duty + step_w[31:0]) : (duty - step_w[31:0]);
                            n    <= n_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scurve_duty_gen.sv
// Bench for scurve_duty_gen.
// Lane 0: TICK_DIV=4, JERK=1, NMAX=4, no clamp.
// Lane 1: TICK_DIV=4, JERK=7, NMAX=4, DUTY_MAX=200.
// Each lane carries a plan-based reference model that is checked every cycle,
// plus literal duty sequences worked out by hand.
module tb_scurve_duty_gen;

    localparam int TD = 4;
    localparam int NM = 4;

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  load;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [31:0] target [2];
    logic [31:0] duty   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint bd(input longint j, input longint k);
        return j * k * (k - 1) / 2;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam logic [31:0] J  = (g == 0) ? 32'd1 : 32'd7;
        localparam logic [31:0] DM = (g == 0) ? 32'hFFFF_FFFF : 32'd200;

        scurve_duty_gen #(
            .TICK_DIV(TD),
            .JERK    (J),
            .NMAX    (NM),
            .DUTY_MAX(DM)
        ) dut (
            .Clk   (clk),
            .Rst_n (rst_n[g]),
            .target(target[g]),
            .load  (load[g]),
            .duty  (duty[g]),
            .busy  (busy[g]),
            .done  (done[g])
        );

        // Reference model: on load, the whole duty trajectory is planned up
        // front; each tick while busy consumes one planned value.
        longint m_duty;
        bit     m_busy;
        bit     m_done;
        int     m_ps;
        longint plan [$];
        longint tg, cur, rem, st, nn, nn2;
        bit     tk, fin;

        always @(posedge clk or negedge rst_n[g]) begin
            if (!rst_n[g]) begin
                m_duty = 0;
                m_busy = 0;
                m_done = 0;
                m_ps   = 0;
                plan.delete();
            end else begin
                tk     = (m_ps == TD - 1);
                m_ps   = tk ? 0 : m_ps + 1;
                m_done = 0;
                if (m_busy) begin
                    if (tk) begin
                        m_duty = plan.pop_front();
                        if (plan.size() == 0) begin
                            m_done = 1;
                            m_busy = 0;
                        end
                    end
                end else if (load[g]) begin
                    tg  = longint'({32'd0, target[g]});
                    if (tg > longint'({32'd0, DM})) tg = longint'({32'd0, DM});
                    cur = m_duty;
                    nn  = 0;
                    plan.delete();
                    do begin
                        rem = (tg >= cur) ? tg - cur : cur - tg;
                        if (nn < NM && rem >= bd(J, nn + 2)) nn2 = nn + 1;
                        else if (nn > 0 && rem >= bd(J, nn + 1)) nn2 = nn;
                        else nn2 = (nn > 0) ? nn - 1 : 0;
                        st = nn2 * longint'({32'd0, J});
                        if (st >= rem || nn2 == 0) begin
                            plan.push_back(tg);
                            fin = 1;
                        end else begin
                            cur = (tg >= cur) ? cur + st : cur - st;
                            plan.push_back(cur);
                            nn  = nn2;
                            fin = 0;
                        end
                    end while (!fin);
                    m_busy = 1;
                end
            end
        end

        always @(negedge clk) begin
            chk($sformatf("lane%0d duty", g), longint'({32'd0, duty[g]}), m_duty);
            chk($sformatf("lane%0d busy", g), longint'(busy[g]), longint'(m_busy));
            chk($sformatf("lane%0d done", g), longint'(done[g]), longint'(m_done));
        end
    end

    // Observers: duty change history, largest step and done pulses.
    longint chg0 [$];
    longint chg1 [$];
    longint prev0 = 0, prev1 = 0, max_step0 = 0, max_duty0 = 0;
    int     done_cnt0 = 0, done_cnt1 = 0;

    always @(negedge clk) begin
        if (longint'({32'd0, duty[0]}) != prev0) begin
            chg0.push_back(longint'({32'd0, duty[0]}));
            if (longint'({32'd0, duty[0]}) > prev0) begin
                if (longint'({32'd0, duty[0]}) - prev0 > max_step0) max_step0 = longint'({32'd0, duty[0]}) - prev0;
            end else begin
                if (prev0 - longint'({32'd0, duty[0]}) > max_step0) max_step0 = prev0 - longint'({32'd0, duty[0]});
            end
            if (longint'({32'd0, duty[0]}) > max_duty0) max_duty0 = longint'({32'd0, duty[0]});
            prev0 = longint'({32'd0, duty[0]});
        end
        if (longint'({32'd0, duty[1]}) != prev1) begin
            chg1.push_back(longint'({32'd0, duty[1]}));
            prev1 = longint'({32'd0, duty[1]});
        end
        if (done[0]) done_cnt0++;
        if (done[1]) done_cnt1++;
    end

    task automatic pulse_load(input int g, input logic [31:0] t);
        @(negedge clk);
        target[g] = t;
        load[g]   = 1'b1;
        @(negedge clk);
        load[g]   = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (done[g]) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, " done seen"}, longint'(ok), 1);
        // let the observers record the final edge
        repeat (2) @(negedge clk);
    endtask

    task automatic check_seq(input string nm, input longint got [$], input longint exp [$]);
        chk({nm, " length"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
    endtask

    longint e_up10 [$] = '{1, 3, 6, 8, 9, 10};
    longint e_dn10 [$] = '{9, 7, 4, 2, 1, 0};
    longint e_clmp [$] = '{7, 21, 42, 70, 98, 126, 154, 175, 189, 196, 200};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst_n     = 2'b00;
        load      = 2'b00;
        target[0] = '0;
        target[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset duty", longint'({32'd0, duty[0]}), 0);
        chk("reset busy", longint'(busy[0]), 0);
        chk("reset done", longint'(done[0]), 0);
        rst_n = 2'b11;
        repeat (2) @(negedge clk);

        // 1: ramp up 0 -> 10
        chg0.delete();
        dc = done_cnt0;
        pulse_load(0, 32'd10);
        chk("t1 busy after load", longint'(busy[0]), 1);
        wait_done(0, 200, "t1");
        check_seq("t1 seq", chg0, e_up10);
        chk("t1 done count", done_cnt0 - dc, 1);
        chk("t1 busy end", longint'(busy[0]), 0);

        // 2: ramp down 10 -> 0
        chg0.delete();
        dc = done_cnt0;
        pulse_load(0, 32'd0);
        wait_done(0, 200, "t2");
        check_seq("t2 seq", chg0, e_dn10);
        chk("t2 done count", done_cnt0 - dc, 1);

        // 3: long ramp, level saturates
        max_step0 = 0;
        max_duty0 = 0;
        pulse_load(0, 32'd100);
        wait_done(0, 400, "t3");
        chk("t3 final duty", longint'({32'd0, duty[0]}), 100);
        chk("t3 max step", max_step0, 4);
        chk("t3 max duty", max_duty0, 100);

        // 4: load while busy is ignored, then load equal to current duty
        dc = done_cnt0;
        pulse_load(0, 32'd40);
        repeat (6) @(negedge clk);
        pulse_load(0, 32'd50);
        wait_done(0, 400, "t4a");
        chk("t4a final duty", longint'({32'd0, duty[0]}), 40);
        chk("t4a done count", done_cnt0 - dc, 1);
        chg0.delete();
        pulse_load(0, 32'd40);
        wait_done(0, TD + 1, "t4b");
        chk("t4b duty unchanged", longint'({32'd0, duty[0]}), 40);
        chk("t4b no duty change", chg0.size(), 0);

        // 5: asynchronous reset in the middle of a profile
        dc = done_cnt0;
        pulse_load(0, 32'd100);
        repeat (10) @(negedge clk);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("t5 duty in reset", longint'({32'd0, duty[0]}), 0);
        chk("t5 busy in reset", longint'(busy[0]), 0);
        chk("t5 done in reset", longint'(done[0]), 0);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5 no done pulse", done_cnt0 - dc, 0);
        chg0.delete();
        pulse_load(0, 32'd10);
        wait_done(0, 200, "t5");
        check_seq("t5 seq", chg0, e_up10);

        // 6: clamp to DUTY_MAX with JERK=7
        chg1.delete();
        pulse_load(1, 32'hFFFF_FFFF);
        wait_done(1, 400, "t6");
        check_seq("t6 seq", chg1, e_clmp);
        chk("t6 final duty", longint'({32'd0, duty[1]}), 200);
        if (chg1.size() >= 2)
            chk("t6 residual below jerk", longint'(chg1[chg1.size()-1] - chg1[chg1.size()-2] < 7), 1);
        chk("t6 done count", done_cnt1, 1);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
